m_phy_rx_sm: RTL and testbench
==============================

# m_phy_rx_sm

Type-1 M-PHY-RX link state machine. It tracks the remote transmitter's line state as seen at the receiver pins (DIF-N/P/Q/Z), with the TX-side power, reset and configuration sequence mirrored on the receive end. It detects burst prepare, burst end, configuration and line-reset conditions, and reports the current receiver mode to the RX datapath and the SAP. It sits between the line-state slicer and the PWM/HS burst decoders.

## Interface
- RESET_COMPLETION, 16: cycles spent in DISABLED before entering HIBERN8.
- T_ACTIVATE, 16: consecutive DIF_N cycles in HIBERN8 required to enter SLEEP.
- T_PWM_PREPARE, 16: consecutive DIF_P cycles in SLEEP required to enter PWM_BURST.
- T_HS_PREPARE, 16: consecutive DIF_P cycles in STALL required to enter HS_BURST.
- T_LINE_RESET, 64: consecutive DIF_P cycles that signal a line reset. Must be greater than T_PWM_PREPARE and greater than T_HS_PREPARE.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- power_on  in  1  supply is up; leaves UNPOWERED.
- phy_reset  in  1  synchronous PHY reset; forces DISABLED.
- sap_reset  in  1  SAP-requested line reset; forces LINE_RESET.
- rct  in  1  hibernate request; honoured in SLEEP, STALL and LINE_CFG.
- line_state  in  2  sliced line state: 0=DIF_N, 1=DIF_P, 2=DIF_Q, 3=DIF_Z.
- pwm_eob  in  1  end-of-burst from the PWM decoder.
- hs_eob  in  1  end-of-burst from the HS decoder.
- cfg_req  in  1  decoder saw a configuration marker inside a burst.
- cfg_done  in  1  LINE_CFG complete.
- cfg_hs  in  1  target mode after LINE_CFG: 1 = STALL, 0 = SLEEP.
- phy_state  out  2  registered mode: 01 = PWM_BURST, 10 = LINE_CFG, 11 = HS_BURST, 00 = any other state.
- busy  out  1  registered; 1 in DISABLED, LINE_RESET, PWM_BURST, HS_BURST and LINE_CFG.
- burst_start  out  1  one-cycle pulse on entry to PWM_BURST or HS_BURST.
- line_reset_det  out  1  one-cycle pulse when the T_LINE_RESET threshold is reached.

## Operation
- States: UNPOWERED, DISABLED, HIBERN8, SLEEP, PWM_BURST, LINE_CFG, STALL, HS_BURST, LINE_RESET.
- Phase counter `count` (32 bits) is cleared on every state change.
- Line-reset counter `lr_count` (32 bits):
  - Increments on each DIF_P cycle in any state except UNPOWERED and DISABLED.
  - Clears on any non-DIF_P cycle.
  - Saturates at T_LINE_RESET-1.
- Priority, evaluated each cycle, highest first:
  1. reset → UNPOWERED.
  2. phy_reset → DISABLED.
  3. sap_reset → LINE_RESET.
  4. DIF_P while lr_count ≥ T_LINE_RESET-1, state not LINE_RESET → LINE_RESET, pulse line_reset_det.
  5. Per-state rules below.
- UNPOWERED: power_on → DISABLED.
- DISABLED: count increments; at count = RESET_COMPLETION-1 → HIBERN8.
- HIBERN8:
  - DIF_N: count increments; at count ≥ T_ACTIVATE-1 → SLEEP.
  - Any other line state: count clears, state holds.
- SLEEP:
  - rct → HIBERN8.
  - DIF_P: count increments; at count ≥ T_PWM_PREPARE-1 → PWM_BURST.
  - Otherwise count clears.
- STALL: same rules as SLEEP, using T_HS_PREPARE and target HS_BURST.
- PWM_BURST: pwm_eob → SLEEP; otherwise cfg_req → LINE_CFG.
- HS_BURST: hs_eob → STALL; otherwise cfg_req → LINE_CFG.
- LINE_CFG: rct → HIBERN8; otherwise cfg_done → STALL if cfg_hs, else SLEEP.
- LINE_RESET: a DIF_N cycle with sap_reset low → SLEEP; lr_count clears.
- Any illegal state encoding → UNPOWERED.

## Timing
- Reset values: state UNPOWERED, count 0, lr_count 0, phy_state 00, busy 0, burst_start 0, line_reset_det 0.
- phy_state and busy are registered from the current state: they lag the state register by one cycle.
- burst_start is registered from the transition condition: it asserts in the same cycle state first reads PWM_BURST or HS_BURST.
- line_reset_det behaves the same way: it asserts in the same cycle state first reads LINE_RESET.
- Prepare timing: with DIF_P from cycle 0, the state reads PWM_BURST after T_PWM_PREPARE edges, and phy_state reads 01 one edge later.
- If the prepare threshold and the line-reset threshold fall on the same cycle, line reset wins.
- DIF_P in LINE_RESET holds the state and emits no further line_reset_det pulse.
- If pwm_eob and cfg_req arrive together, eob wins; hs_eob and cfg_req resolve the same way.
- phy_reset or sap_reset mid-burst takes effect on the next edge; no completion handshake is given.
- count never wraps inside a legal flow, because every threshold forces a state exit.

## Test plan
- Bring-up:
  - Stimulus: reset, then power_on=1, line Z for 20 cycles, then DIF_N for 16 cycles.
  - Response: DISABLED for 16 cycles, busy=1, then HIBERN8; SLEEP after the 16th DIF_N cycle; busy=0.
- PWM burst entry and exit:
  - Stimulus: in SLEEP, DIF_P for 16 cycles; later pwm_eob.
  - Response: burst_start pulses once; phy_state=01 the next cycle; after pwm_eob the state is SLEEP and phy_state returns to 00.
- Interrupted prepare:
  - Stimulus: in STALL, DIF_P ×10, then DIF_N ×1, then DIF_P ×16.
  - Response: HS_BURST only after the final 16 DIF_P cycles; phy_state=11.
- Configuration:
  - Stimulus: in HS_BURST, cfg_req; then cfg_done with cfg_hs=0.
  - Response: LINE_CFG with phy_state=10, then SLEEP.
  - Also apply rct during LINE_CFG: state goes to HIBERN8.
- Line reset:
  - Stimulus: in PWM_BURST, DIF_P held for 64 cycles, then DIF_N.
  - Response: line_reset_det pulses once; state LINE_RESET with busy=1; SLEEP after the DIF_N cycle.
  - Repeat with sap_reset: identical path, no line_reset_det pulse.
- Priority:
  - Stimulus: phy_reset and sap_reset asserted together mid-HS_BURST.
  - Response: DISABLED.
  - Stimulus: reset together with power_on.
  - Response: UNPOWERED.

Source files
------------

// File: rtl/m_phy_rx_sm.sv
// Type-1 M-PHY receive-side link state machine: tracks the remote TX line state
// and reports receiver mode, burst entry and line-reset detection.
module m_phy_rx_sm #(
    parameter int unsigned RESET_COMPLETION = 16,
    parameter int unsigned T_ACTIVATE       = 16,
    parameter int unsigned T_PWM_PREPARE    = 16,
    parameter int unsigned T_HS_PREPARE     = 16,
    parameter int unsigned T_LINE_RESET     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_on,
    input  logic       phy_reset,
    input  logic       sap_reset,
    input  logic       rct,
    input  logic [1:0] line_state,
    input  logic       pwm_eob,
    input  logic       hs_eob,
    input  logic       cfg_req,
    input  logic       cfg_done,
    input  logic       cfg_hs,
    output logic [1:0] phy_state,
    output logic       busy,
    output logic       burst_start,
    output logic       line_reset_det
);

    localparam int unsigned CW = 32;

    localparam logic [CW-1:0] RC_LAST  = CW'(RESET_COMPLETION - 1);
    localparam logic [CW-1:0] ACT_LAST = CW'(T_ACTIVATE - 1);
    localparam logic [CW-1:0] PWM_LAST = CW'(T_PWM_PREPARE - 1);
    localparam logic [CW-1:0] HS_LAST  = CW'(T_HS_PREPARE - 1);
    localparam logic [CW-1:0] LR_LAST  = CW'(T_LINE_RESET - 1);

    typedef enum logic [3:0] {
        S_UNPOWERED  = 4'd0,
        S_DISABLED   = 4'd1,
        S_HIBERN8    = 4'd2,
        S_SLEEP      = 4'd3,
        S_PWM_BURST  = 4'd4,
        S_LINE_CFG   = 4'd5,
        S_STALL      = 4'd6,
        S_HS_BURST   = 4'd7,
        S_LINE_RESET = 4'd8
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] lr_count;

    logic dif_n;
    logic dif_p;
    logic lr_hit;

    assign dif_n  = (line_state == 2'd0);
    assign dif_p  = (line_state == 2'd1);
    assign lr_hit = dif_p && (lr_count >= LR_LAST) && (state != S_LINE_RESET);

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            S_PWM_BURST: mode_of = 2'b01;
            S_LINE_CFG:  mode_of = 2'b10;
            S_HS_BURST:  mode_of = 2'b11;
            default:     mode_of = 2'b00;
        endcase
    endfunction

    function automatic logic busy_of(input state_t s);
        busy_of = (s == S_DISABLED) || (s == S_LINE_RESET) || (s == S_PWM_BURST) ||
                  (s == S_HS_BURST) || (s == S_LINE_CFG);
    endfunction

    // count stays cleared unless a branch below extends the current phase
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_UNPOWERED;
            count          <= '0;
            lr_count       <= '0;
            phy_state      <= 2'b00;
            busy           <= 1'b0;
            burst_start    <= 1'b0;
            line_reset_det <= 1'b0;
        end else begin
            phy_state      <= mode_of(state);
            busy           <= busy_of(state);
            burst_start    <= 1'b0;
            line_reset_det <= 1'b0;
            count          <= '0;

            if ((state == S_UNPOWERED) || (state == S_DISABLED) || !dif_p) begin
                lr_count <= '0;
            end else if (lr_count < LR_LAST) begin
                lr_count <= lr_count + CW'(1);
            end

            if (phy_reset) begin
                state <= S_DISABLED;
            end else if (sap_reset) begin
                state <= S_LINE_RESET;
            end else if (lr_hit) begin
                state          <= S_LINE_RESET;
                line_reset_det <= 1'b1;
            end else begin
                case (state)
                    S_UNPOWERED: if (power_on) state <= S_DISABLED;
                    S_DISABLED: begin
                        if (count == RC_LAST) state <= S_HIBERN8;
                        else                  count <= count + CW'(1);
                    end
                    S_HIBERN8: begin
                        if (dif_n) begin
                            if (count >= ACT_LAST) state <= S_SLEEP;
                            else                   count <= count + CW'(1);
                        end
                    end
                    S_SLEEP: begin
                        if (rct) begin
                            state <= S_HIBERN8;
                        end else if (dif_p) begin
                            if (count >= PWM_LAST) begin
                                state       <= S_PWM_BURST;
                                burst_start <= 1'b1;
                            end else begin
                                count <= count + CW'(1);
                            end
                        end
                    end
                    S_STALL: begin
                        if (rct) begin
                            state <= S_HIBERN8;
                        end else if (dif_p) begin
                            if (count >= HS_LAST) begin
                                state       <= S_HS_BURST;
                                burst_start <= 1'b1;
                            end else begin
                                count <= count + CW'(1);
                            end
                        end
                    end
                    S_PWM_BURST: begin
                        if (pwm_eob)      state <= S_SLEEP;
                        else if (cfg_req) state <= S_LINE_CFG;
                    end
                    S_HS_BURST: begin
                        if (hs_eob)       state <= S_STALL;
                        else if (cfg_req) state <= S_LINE_CFG;
                    end
                    S_LINE_CFG: begin
                        if (rct)           state <= S_HIBERN8;
                        else if (cfg_done) state <= cfg_hs ? S_STALL : S_SLEEP;
                    end
                    S_LINE_RESET: if (dif_n) state <= S_SLEEP;
                    default: state <= S_UNPOWERED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m_phy_rx_sm.sv
// Directed bench for m_phy_rx_sm: per-cycle check against a cycle-counting
// model of the link rules, plus hand-computed checkpoints along the flow.
module tb_m_phy_rx_sm;

    localparam int RC  = 16;
    localparam int TA  = 16;
    localparam int TPP = 16;
    localparam int THP = 16;
    localparam int TLR = 64;

    localparam int UNP = 0, DIS = 1, HIB = 2, SLP = 3, PWM = 4, CFG = 5, STL = 6, HSB = 7, LRS = 8;
    localparam logic [1:0] LN = 2'd0, LP = 2'd1, LZ = 2'd3;

    logic       clk = 1'b0;
    logic       reset, power_on, phy_reset, sap_reset, rct;
    logic [1:0] line_state;
    logic       pwm_eob, hs_eob, cfg_req, cfg_done, cfg_hs;
    logic [1:0] phy_state;
    logic       busy, burst_start, line_reset_det;

    int total = 0;
    int bad   = 0;

    m_phy_rx_sm dut (
        .clk(clk), .reset(reset), .power_on(power_on), .phy_reset(phy_reset),
        .sap_reset(sap_reset), .rct(rct), .line_state(line_state),
        .pwm_eob(pwm_eob), .hs_eob(hs_eob), .cfg_req(cfg_req),
        .cfg_done(cfg_done), .cfg_hs(cfg_hs), .phy_state(phy_state),
        .busy(busy), .burst_start(burst_start), .line_reset_det(line_reset_det)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // model: mode per state, cycles in the current phase, and the length of the DIF_P run
    int         ms = UNP;
    int         phase = 0;
    int         prun = 0;
    logic [1:0] e_phy = 2'b00;
    logic       e_busy = 1'b0, e_bs = 1'b0, e_lrd = 1'b0;

    function automatic logic [1:0] mode_of(input int s);
        return (s == PWM) ? 2'b01 : (s == CFG) ? 2'b10 : (s == HSB) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic busy_of(input int s);
        return (s == DIS) || (s == LRS) || (s == PWM) || (s == HSB) || (s == CFG);
    endfunction

    task automatic model_step();
        bit p, n, forced, qual;
        int ns;
        p = (line_state == LP);
        n = (line_state == LN);
        if (reset) begin
            ms = UNP; phase = 0; prun = 0;
            e_phy = 2'b00; e_busy = 1'b0; e_bs = 1'b0; e_lrd = 1'b0;
            return;
        end
        e_phy  = mode_of(ms);
        e_busy = busy_of(ms);
        e_lrd  = 1'b0;
        ns     = ms;
        forced = 1'b1;
        qual   = 1'b0;
        if (phy_reset) ns = DIS;
        else if (sap_reset) ns = LRS;
        else if (p && prun >= TLR - 1 && ms != LRS) begin
            ns = LRS; e_lrd = 1'b1;
        end else begin
            forced = 1'b0;
            case (ms)
                UNP: if (power_on) ns = DIS;
                DIS: begin qual = 1'b1; if (phase + 1 == RC) ns = HIB; end
                HIB: begin qual = n; if (n && phase + 1 >= TA) ns = SLP; end
                SLP: if (rct) ns = HIB; else begin qual = p; if (p && phase + 1 >= TPP) ns = PWM; end
                STL: if (rct) ns = HIB; else begin qual = p; if (p && phase + 1 >= THP) ns = HSB; end
                PWM: if (pwm_eob) ns = SLP; else if (cfg_req) ns = CFG;
                HSB: if (hs_eob) ns = STL; else if (cfg_req) ns = CFG;
                CFG: if (rct) ns = HIB; else if (cfg_done) ns = cfg_hs ? STL : SLP;
                LRS: if (n) ns = SLP;
                default: ns = UNP;
            endcase
        end
        e_bs  = (ns != ms) && (ns == PWM || ns == HSB);
        phase = (forced || ns != ms || !qual) ? 0 : phase + 1;
        prun  = (ms == UNP || ms == DIS || !p) ? 0 : prun + 1;
        ms    = ns;
    endtask

    // inputs change on negedge; model and DUT both sample them at posedge
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("phy_state", int'(phy_state), int'(e_phy));
            chk("busy", int'(busy), int'(e_busy));
            chk("burst_start", int'(burst_start), int'(e_bs));
            chk("line_reset_det", int'(line_reset_det), int'(e_lrd));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_entry();
        line_state = LP; tick(TPP);
        line_state = LZ; tick(1);
    endtask

    task automatic pwm_to_stall();
        cfg_req = 1'b1; tick(1); cfg_req = 1'b0;
        cfg_done = 1'b1; cfg_hs = 1'b1; tick(1);
        cfg_done = 1'b0; cfg_hs = 1'b0;
    endtask

    initial begin
        reset = 1'b1; power_on = 1'b0; phy_reset = 1'b0; sap_reset = 1'b0; rct = 1'b0;
        line_state = LZ; pwm_eob = 1'b0; hs_eob = 1'b0; cfg_req = 1'b0;
        cfg_done = 1'b0; cfg_hs = 1'b0;
        @(negedge clk);
        tick(3);
        chk("rst_phy_state", int'(phy_state), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_burst_start", int'(burst_start), 0);
        chk("rst_lrd", int'(line_reset_det), 0);
        reset = 1'b0;

        // bring-up
        power_on = 1'b1; line_state = LZ;
        tick(2);  chk("bringup_busy_disabled", int'(busy), 1);
        tick(15); chk("bringup_busy_last_disabled", int'(busy), 1);
        tick(3);  chk("bringup_busy_hibern8", int'(busy), 0);
        line_state = LN; tick(TA);

        // PWM burst entry and exit
        line_state = LP; tick(TPP - 1);
        chk("pwm_no_start_early", int'(burst_start), 0);
        tick(1);
        chk("pwm_burst_start", int'(burst_start), 1);
        chk("pwm_phy_lag", int'(phy_state), 0);
        line_state = LZ; tick(1);
        chk("pwm_start_once", int'(burst_start), 0);
        chk("pwm_phy_state", int'(phy_state), 1);
        pwm_eob = 1'b1; cfg_req = 1'b1; tick(1);
        pwm_eob = 1'b0; cfg_req = 1'b0; tick(1);
        chk("pwm_eob_phy_state", int'(phy_state), 0);
        chk("pwm_eob_busy", int'(busy), 0);

        // interrupted HS prepare
        pwm_entry(); pwm_to_stall();
        line_state = LP; tick(10);
        line_state = LN; tick(1);
        line_state = LP; tick(THP - 1);
        chk("hs_no_start_early", int'(burst_start), 0);
        tick(1);
        chk("hs_burst_start", int'(burst_start), 1);
        line_state = LZ; tick(1);
        chk("hs_phy_state", int'(phy_state), 3);

        // configuration out of HS, back to SLEEP
        cfg_req = 1'b1; tick(1); cfg_req = 1'b0; tick(1);
        chk("cfg_phy_state", int'(phy_state), 2);
        cfg_done = 1'b1; tick(1); cfg_done = 1'b0; tick(1);
        chk("cfg_done_phy_state", int'(phy_state), 0);
        chk("cfg_done_busy", int'(busy), 0);

        // rct in LINE_CFG goes to HIBERN8, where DIF_P cannot start a burst
        pwm_entry();
        cfg_req = 1'b1; tick(1); cfg_req = 1'b0;
        rct = 1'b1; tick(1); rct = 1'b0;
        line_state = LP; tick(TPP + 2);
        chk("hib_no_burst", int'(phy_state), 0);
        line_state = LN; tick(TA);

        // line reset from DIF_P held inside PWM_BURST
        pwm_entry();
        line_state = LP; tick(TLR - 1);
        chk("lr_not_yet", int'(line_reset_det), 0);
        tick(1);
        chk("lr_detect", int'(line_reset_det), 1);
        tick(3);
        chk("lr_single_pulse", int'(line_reset_det), 0);
        chk("lr_busy", int'(busy), 1);
        line_state = LN; tick(1);
        line_state = LZ; tick(1);
        chk("lr_exit_busy", int'(busy), 0);

        // SAP line reset: same path, no detect pulse; DIF_N ignored while sap_reset is high
        pwm_entry();
        sap_reset = 1'b1; tick(1);
        line_state = LN; tick(2);
        sap_reset = 1'b0; line_state = LZ; tick(2);
        chk("sap_busy", int'(busy), 1);
        line_state = LN; tick(1);
        line_state = LZ; tick(1);
        chk("sap_exit_busy", int'(busy), 0);

        // phy_reset and sap_reset together mid-HS_BURST
        pwm_entry(); pwm_to_stall();
        line_state = LP; tick(THP);
        line_state = LZ;
        phy_reset = 1'b1; sap_reset = 1'b1; tick(1);
        phy_reset = 1'b0; sap_reset = 1'b0; tick(1);
        chk("prio_disabled_phy", int'(phy_state), 0);
        chk("prio_disabled_busy", int'(busy), 1);
        tick(RC + 1);
        chk("prio_hib_busy", int'(busy), 0);

        // reset dominates power_on
        power_on = 1'b1; reset = 1'b1; tick(2);
        chk("reset_prio_busy", int'(busy), 0);
        reset = 1'b0; power_on = 1'b0; tick(3);
        chk("unpowered_stays", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
